// File: rtl/linear_dump_ctrl.sv
// Arms a linear-execution extraction run: waits a programmable delay, blocks pc_set,
// and streams fetched words through a small FIFO. Optional macro: LINEAR_DUMP_ALARM_STOP_EN.
module linear_dump_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic [CNT_W-1:0] max_words_i,
  input  logic             instr_valid_i,
  input  logic [31:0]      instr_rdata_i,
  input  logic             alarm_i,
  output logic             pc_set_block_o,
  output logic             dump_valid_o,
  input  logic             dump_ready_i,
  output logic [31:0]      dump_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       cause_o,
  output logic             overflow_o
);

  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_LIMIT = 2'd1;
  localparam logic [1:0] CAUSE_ALARM = 2'd2;
  localparam logic [1:0] CAUSE_OVF   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_EXTRACT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause_next;
  logic             r_overflow;
  logic             w_ovf_next;
  logic             w_start;

  logic [CNT_W-1:0] r_delay_cnt;
  logic [CNT_W-1:0] r_limit;
  logic [CNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0] w_word_inc;

  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push_req;
  logic             w_push;
  logic             w_drop;
  logic             w_limit_hit;
  logic             w_alarm;

`ifdef LINEAR_DUMP_ALARM_STOP_EN
  assign w_alarm = alarm_i && ((r_state == S_DELAY) || (r_state == S_EXTRACT));
`else
  // Alarm input is parked; it never ends a run in this build.
  assign w_alarm = 1'b0 & alarm_i;
`endif

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH_C);
  assign w_pop      = !w_empty && dump_ready_i;
  // An alarm cycle captures nothing, so the drained words are exactly those seen before it.
  assign w_push_req = (r_state == S_EXTRACT) && instr_valid_i && !w_alarm;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  assign w_word_inc  = (&r_word_cnt) ? r_word_cnt : r_word_cnt + 1'b1;
  assign w_limit_hit = w_push && (r_limit != '0) && (w_word_inc == r_limit);

  always_comb begin
    w_state_next = r_state;
    w_cause_next = r_cause;
    w_ovf_next   = r_overflow;
    w_start      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_start      = 1'b1;
          w_cause_next = CAUSE_NONE;
          w_ovf_next   = 1'b0;
          w_state_next = (delay_i == '0) ? S_EXTRACT : S_DELAY;
        end
      end
      S_DELAY: begin
        if (w_alarm) begin
          w_cause_next = CAUSE_ALARM;
          w_state_next = w_empty ? S_DONE : S_DRAIN;
        end else if (r_delay_cnt <= CNT_W'(1)) begin
          w_state_next = S_EXTRACT;
        end
      end
      S_EXTRACT: begin
        if (w_alarm) begin
          w_cause_next = CAUSE_ALARM;
          w_state_next = S_DRAIN;
        end else if (w_drop) begin
          w_cause_next = CAUSE_OVF;
          w_ovf_next   = 1'b1;
          w_state_next = S_DRAIN;
        end else if (w_limit_hit) begin
          w_cause_next = CAUSE_LIMIT;
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_empty) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cause     <= CAUSE_NONE;
      r_overflow  <= 1'b0;
      r_delay_cnt <= '0;
      r_limit     <= '0;
      r_word_cnt  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cause    <= w_cause_next;
      r_overflow <= w_ovf_next;
      if (w_start) begin
        r_delay_cnt <= delay_i;
        r_limit     <= max_words_i;
        r_word_cnt  <= '0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
      end else begin
        if ((r_state == S_DELAY) && (r_delay_cnt != '0)) begin
          r_delay_cnt <= r_delay_cnt - 1'b1;
        end
        if (w_push) begin
          r_wr_ptr   <= r_wr_ptr + 1'b1;
          r_word_cnt <= w_word_inc;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= instr_rdata_i;
    end
  end

  assign pc_set_block_o = (r_state == S_EXTRACT);
  assign busy_o         = (r_state == S_DELAY) || (r_state == S_EXTRACT) || (r_state == S_DRAIN);
  assign done_o         = (r_state == S_DONE);
  assign dump_valid_o   = !w_empty;
  assign dump_data_o    = w_empty ? 32'd0 : r_mem[r_rd_ptr];
  assign cause_o        = r_cause;
  assign overflow_o     = r_overflow;

endmodule

// File: tb/tb_linear_dump_ctrl.sv
// Directed bench for linear_dump_ctrl; popped words are checked against a scoreboard queue.
module tb_linear_dump_ctrl;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 32;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic [CNT_W-1:0] delay_i = '0;
  logic [CNT_W-1:0] max_words_i = '0;
  logic             instr_valid_i = 1'b0;
  logic [31:0]      instr_rdata_i = '0;
  logic             alarm_i = 1'b0;
  logic             pc_set_block_o;
  logic             dump_valid_o;
  logic             dump_ready_i = 1'b0;
  logic [31:0]      dump_data_o;
  logic             busy_o;
  logic             done_o;
  logic [1:0]       cause_o;
  logic             overflow_o;

  int          n_checks = 0;
  int          n_errors = 0;
  int          pop_cnt  = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];

  linear_dump_ctrl #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .delay_i       (delay_i),
    .max_words_i   (max_words_i),
    .instr_valid_i (instr_valid_i),
    .instr_rdata_i (instr_rdata_i),
    .alarm_i       (alarm_i),
    .pc_set_block_o(pc_set_block_o),
    .dump_valid_o  (dump_valid_o),
    .dump_ready_i  (dump_ready_i),
    .dump_data_o   (dump_data_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .cause_o       (cause_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy_o && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy_o), 32'd0);
    repeat (2) tick();
  endtask

  // Output monitor: a word leaves on the edge following a negedge that sees valid && ready.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (done_o) done_cnt++;
      if (dump_valid_o && dump_ready_i) begin
        pop_cnt++;
        chk("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("dump_data", dump_data_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pops0;
    int dones0;

    // Reset state
    repeat (2) tick();
    chk("rst_pc_set_block", 32'(pc_set_block_o), 32'd0);
    chk("rst_dump_valid",   32'(dump_valid_o),   32'd0);
    chk("rst_busy",         32'(busy_o),         32'd0);
    chk("rst_done",         32'(done_o),         32'd0);
    chk("rst_cause",        32'(cause_o),        32'd0);
    chk("rst_overflow",     32'(overflow_o),     32'd0);
    chk("rst_dump_data",    dump_data_o,         32'd0);
    rst_i = 1'b0;
    tick();
    chk("idle_no_start_busy", 32'(busy_o), 32'd0);

    // Delay 3, limit 2, ready held high
    pops0 = pop_cnt; dones0 = done_cnt;
    dump_ready_i = 1'b1; instr_valid_i = 1'b1;
    delay_i = 3; max_words_i = 2; start_i = 1'b1; instr_rdata_i = 32'h1000_0000;
    tick();
    start_i = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      instr_rdata_i = 32'h1000_0000 + k;
      if (k == 4 || k == 5) exp_q.push_back(instr_rdata_i);
      chk("t1_pc_set_block", 32'(pc_set_block_o), 32'(k == 4 || k == 5));
      chk("t1_busy", 32'(busy_o), 32'(k <= 7));
      tick();
    end
    chk("t1_cause", 32'(cause_o), 32'd1);
    chk("t1_words", 32'(pop_cnt - pops0), 32'd2);
    chk("t1_done_pulses", 32'(done_cnt - dones0), 32'd1);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Overflow: ready low, unlimited, five words into a four-deep buffer
    pops0 = pop_cnt; dones0 = done_cnt;
    dump_ready_i = 1'b0; instr_valid_i = 1'b1;
    delay_i = 0; max_words_i = 0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      instr_rdata_i = 32'h2000_0000 + k;
      if (k <= 4) exp_q.push_back(instr_rdata_i);
      chk("t2_pc_set_block", 32'(pc_set_block_o), 32'd1);
      tick();
    end
    instr_valid_i = 1'b0;
    chk("t2_overflow", 32'(overflow_o), 32'd1);
    chk("t2_cause", 32'(cause_o), 32'd3);
    chk("t2_pc_set_released", 32'(pc_set_block_o), 32'd0);
    chk("t2_busy_drain", 32'(busy_o), 32'd1);
    chk("t2_dump_valid", 32'(dump_valid_o), 32'd1);
    chk("t2_head", dump_data_o, 32'h2000_0001);
    tick();
    chk("t2_head_stable", dump_data_o, 32'h2000_0001);
    chk("t2_no_pop_while_not_ready", 32'(pop_cnt - pops0), 32'd0);
    dump_ready_i = 1'b1;
    wait_idle("t2_drain_timeout", 20);
    chk("t2_words", 32'(pop_cnt - pops0), 32'd4);
    chk("t2_done_pulses", 32'(done_cnt - dones0), 32'd1);
    chk("t2_overflow_sticky", 32'(overflow_o), 32'd1);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Alarm in EXTRACT after one captured word
    pops0 = pop_cnt;
    dump_ready_i = 1'b1; instr_valid_i = 1'b1;
    delay_i = 1; max_words_i = 3; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      instr_rdata_i = 32'h3000_0000 + k;
      alarm_i = (k == 3);
`ifdef LINEAR_DUMP_ALARM_STOP_EN
      if (k == 2) exp_q.push_back(instr_rdata_i);
      if (k <= 5) chk("t3_pc_set_block", 32'(pc_set_block_o), 32'(k == 2 || k == 3));
`else
      if (k >= 2 && k <= 4) exp_q.push_back(instr_rdata_i);
      if (k <= 5) chk("t3_pc_set_block", 32'(pc_set_block_o), 32'(k >= 2 && k <= 4));
`endif
      tick();
    end
    alarm_i = 1'b0; instr_valid_i = 1'b0;
    wait_idle("t3_timeout", 20);
`ifdef LINEAR_DUMP_ALARM_STOP_EN
    chk("t3_cause", 32'(cause_o), 32'd2);
    chk("t3_words", 32'(pop_cnt - pops0), 32'd1);
`else
    chk("t3_cause", 32'(cause_o), 32'd1);
    chk("t3_words", 32'(pop_cnt - pops0), 32'd3);
`endif
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-EXTRACT with two buffered words
    dump_ready_i = 1'b0; instr_valid_i = 1'b1;
    delay_i = 0; max_words_i = 0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      instr_rdata_i = 32'h4000_0000 + k;
      tick();
    end
    instr_valid_i = 1'b0;
    chk("t4_pre_valid", 32'(dump_valid_o), 32'd1);
    chk("t4_pre_pc_set_block", 32'(pc_set_block_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("t4_rst_pc_set_block", 32'(pc_set_block_o), 32'd0);
    chk("t4_rst_dump_valid",   32'(dump_valid_o),   32'd0);
    chk("t4_rst_busy",         32'(busy_o),         32'd0);
    chk("t4_rst_done",         32'(done_o),         32'd0);
    chk("t4_rst_overflow",     32'(overflow_o),     32'd0);
    chk("t4_rst_cause",        32'(cause_o),        32'd0);
    chk("t4_rst_dump_data",    dump_data_o,         32'd0);
    exp_q.delete();
    tick();
    rst_i = 1'b0;
    repeat (2) tick();
    chk("t4_stay_idle", 32'(busy_o), 32'd0);
    chk("t4_buffer_empty", 32'(dump_valid_o), 32'd0);
    pops0 = pop_cnt;
    dump_ready_i = 1'b1; instr_valid_i = 1'b1;
    delay_i = 2; max_words_i = 1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      instr_rdata_i = 32'h4100_0000 + k;
      if (k == 3) exp_q.push_back(instr_rdata_i);
      chk("t4_pc_set_block", 32'(pc_set_block_o), 32'(k == 3));
      tick();
    end
    wait_idle("t4_timeout", 20);
    chk("t4_cause", 32'(cause_o), 32'd1);
    chk("t4_words", 32'(pop_cnt - pops0), 32'd1);

    // Alarm, full-buffer push and limit-reaching push in one cycle
    pops0 = pop_cnt;
    dump_ready_i = 1'b0; instr_valid_i = 1'b1;
    delay_i = 0; max_words_i = 5; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      instr_rdata_i = 32'h5000_0000 + k;
      alarm_i = (k == 5);
      if (k <= 4) exp_q.push_back(instr_rdata_i);
      tick();
    end
    alarm_i = 1'b0; instr_valid_i = 1'b0;
`ifdef LINEAR_DUMP_ALARM_STOP_EN
    chk("t5_cause", 32'(cause_o), 32'd2);
`else
    chk("t5_cause", 32'(cause_o), 32'd3);
`endif
    chk("t5_busy_drain", 32'(busy_o), 32'd1);
    dump_ready_i = 1'b1;
    wait_idle("t5_timeout", 20);
    chk("t5_words", 32'(pop_cnt - pops0), 32'd4);

    // start_i while busy is ignored
    pops0 = pop_cnt; dones0 = done_cnt;
    dump_ready_i = 1'b1; instr_valid_i = 1'b1;
    delay_i = 2; max_words_i = 1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      start_i     = (k == 2 || k == 4);
      delay_i     = (k == 2 || k == 4) ? 0 : 2;
      max_words_i = (k == 2 || k == 4) ? 3 : 1;
      instr_rdata_i = 32'h6000_0000 + k;
      if (k == 3) exp_q.push_back(instr_rdata_i);
      chk("t6_pc_set_block", 32'(pc_set_block_o), 32'(k == 3));
      chk("t6_busy", 32'(busy_o), 32'(k <= 5));
      tick();
    end
    start_i = 1'b0; instr_valid_i = 1'b0;
    chk("t6_cause", 32'(cause_o), 32'd1);
    chk("t6_words", 32'(pop_cnt - pops0), 32'd1);
    chk("t6_done_pulses", 32'(done_cnt - dones0), 32'd1);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/linear_dump_ctrl.md
LINEAR_DUMP_CTRL -- requirements
Module: linear_dump_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, power-of-two capture buffer depth (2..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of the delay and word counters.
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start_i  input  1  one-cycle pulse arming an extraction run.
REQ-006 SHALL have port delay_i  input  CNT_W  cycles to wait before suppressing control flow, sampled on start_i.
REQ-007 SHALL have port max_words_i  input  CNT_W  words to capture, 0 = unlimited, sampled on start_i.
REQ-008 SHALL have port instr_valid_i  input  1  fetch-stage instruction valid.
REQ-009 SHALL have port instr_rdata_i  input  32  fetched instruction word.
REQ-010 SHALL have port alarm_i  input  1  LDM detector alarm.
REQ-011 SHALL have port pc_set_block_o  output  1  forces core pc_set low (linear execution).
REQ-012 SHALL have port dump_valid_o / dump_ready_i / dump_data_o  output/input/output  1/1/32  capture stream handshake.
REQ-013 SHALL have port busy_o  output  1  run in progress (DELAY, EXTRACT, DRAIN).
REQ-014 SHALL have port done_o  output  1  one-cycle pulse on entry to DONE.
REQ-015 SHALL have port cause_o  output  2  end cause: 0 none, 1 word limit, 2 alarm, 3 overflow; held until next start_i.
REQ-016 SHALL have port overflow_o  output  1  sticky, a valid word was dropped on a full buffer.

Function
REQ-017 SHALL implement FSM states IDLE, DELAY, EXTRACT, DRAIN, DONE; DONE returns to IDLE next cycle.
REQ-018 SHALL, in IDLE, on start_i load delay counter with delay_i, word limit with max_words_i, clear cause_o, overflow_o, buffer; go to DELAY (EXTRACT directly if delay_i = 0).
REQ-019 SHALL decrement delay counter once per cycle in DELAY; move to EXTRACT the cycle after it reaches 1 (exactly delay_i cycles in DELAY).
REQ-020 SHALL assert pc_set_block_o from the first EXTRACT cycle until leaving EXTRACT, combinationally from state.
REQ-021 SHALL push instr_rdata_i into the buffer every EXTRACT cycle with instr_valid_i = 1; words in DELAY are not captured.
REQ-022 SHALL count pushed words; when count reaches a non-zero max_words_i, set cause 1 and go to DRAIN after that push.
REQ-023 SHALL, on push to a full buffer, drop the word, set overflow_o, set cause 3, go to DRAIN; a simultaneous pop frees the slot (no overflow).
REQ-024 SHALL present buffer head on dump_data_o with dump_valid_o = not empty; pop on dump_valid_o and dump_ready_i; data stable while valid and not ready.
REQ-025 SHALL stay in DRAIN until the buffer is empty, then enter DONE.
REQ-026 SHALL ignore start_i outside IDLE.
REQ-027 SHALL give priority, when several end conditions hit in one cycle: alarm > overflow > word limit.
REQ-028 SHALL wrap-free: word counter saturates at all-ones when max_words_i = 0.

Reset
REQ-029 SHALL, on rst_i asserted (any time, mid-run included), immediately enter IDLE, empty buffer, clear counters; pc_set_block_o, dump_valid_o, busy_o, done_o, overflow_o = 0, cause_o = 0, dump_data_o = 0.
REQ-030 SHALL resume only on a start_i after rst_i deasserts.

Configuration
REQ-031 SHALL honour macro LINEAR_DUMP_ALARM_STOP_EN: defined -> alarm_i in DELAY or EXTRACT sets cause 2 and goes to DRAIN (DELAY with empty buffer goes to DONE); undefined -> alarm_i ignored, cause 2 never produced.

Verification
REQ-032 SHALL check: start_i with delay_i=3, max_words_i=2, valid every cycle, ready=1 -> pc_set_block_o rises 4 cycles after start, 2 words out, cause_o=1, done_o pulses once.
REQ-033 SHALL check: dump_ready_i=0, FIFO_DEPTH=4, max_words_i=0, 5 valid words -> 4 held, overflow_o=1, cause_o=3; raising ready drains 4 words then DONE.
REQ-034 SHALL check: macro defined, alarm_i in EXTRACT after 1 word -> cause_o=2, pc_set_block_o falls next cycle, 1 word drained; macro undefined -> run continues.
REQ-035 SHALL check: rst_i pulse mid-EXTRACT with 2 buffered words -> all outputs 0 in same cycle, buffer empty, subsequent start_i runs normally.
REQ-036 SHALL check: alarm, full-buffer push and limit-reaching push same cycle -> cause_o=2.
REQ-037 SHALL check: start_i during busy -> no reload, run ends with original parameters.
